// File: rtl/processador_parametrizado_if.sv
// Load port, input port and observable state of processador_parametrizado.
// The bench or host drives the master side; the core sits on the slave side.
interface processador_parametrizado_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N_OUT  = 2
);
    logic                      carga_en;
    logic [ADDR_W-1:0]         carga_addr;
    logic [DATA_W-1:0]         carga_dado;
    logic [DATA_W-1:0]         entrada;
    logic [N_OUT*DATA_W-1:0]   saida;
    logic                      halted;
    logic [ADDR_W-1:0]         pc;

    modport master (
        output carga_en, carga_addr, carga_dado, entrada,
        input  saida, halted, pc
    );

    modport slave (
        input  carga_en, carga_addr, carga_dado, entrada,
        output saida, halted, pc
    );
endinterface

// File: rtl/processador_parametrizado.sv
// Multicycle accumulator core: two-word instructions, fixed F1/F2/EX cadence,
// NZVC flags, unified program/data memory with a load port and an output bank.
module processador_parametrizado #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N_OUT  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    processador_parametrizado_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned MSB   = DATA_W - 1;

    typedef enum logic [1:0] {F1, F2, EX, HALT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_JMP, OP_JZ, OP_JN, OP_JC, OP_IN, OP_OUT, OP_RSV, OP_HLT
    } opcode_t;

    logic [DATA_W-1:0]       mem [DEPTH];
    state_t                  state;
    logic [ADDR_W-1:0]       pc;
    logic [DATA_W-1:0]       acc;
    logic [3:0]              ir;
    logic [DATA_W-1:0]       opr;
    logic                    fn, fz, fv, fc;
    logic [N_OUT*DATA_W-1:0] saida;
    logic                    halted;

    opcode_t           opcode;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] mem_pc, mem_op;
    logic [DATA_W+4:0] opr_ext;

    assign opcode  = opcode_t'(ir);
    assign op_addr = opr[ADDR_W-1:0];
    assign mem_pc  = mem[pc];
    assign mem_op  = mem[op_addr];
    assign opr_ext = {5'b0, opr};

    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   ext;
    logic              acc_we, flags_we, take;
    logic [3:0]        flags_nx;
    logic [N_OUT-1:0]  out_sel;

    always_comb begin
        res      = mem_op;
        ext      = '0;
        acc_we   = 1'b0;
        flags_we = 1'b0;
        take     = 1'b0;
        flags_nx = {fn, fz, fv, fc};
        case (opcode)
            OP_LDI: begin res = opr;         acc_we = 1'b1; end
            OP_LDA: begin res = mem_op;      acc_we = 1'b1; end
            OP_AND: begin res = acc & mem_op; acc_we = 1'b1; end
            OP_OR:  begin res = acc | mem_op; acc_we = 1'b1; end
            OP_IN:  begin res = bus.entrada; acc_we = 1'b1; end
            OP_ADD: begin
                ext    = {1'b0, acc} + {1'b0, mem_op};
                res    = ext[DATA_W-1:0];
                acc_we = 1'b1;
            end
            OP_SUB: begin
                ext    = {1'b0, acc} - {1'b0, mem_op};
                res    = ext[DATA_W-1:0];
                acc_we = 1'b1;
            end
            OP_JMP: take = 1'b1;
            OP_JZ:  take = fz;
            OP_JN:  take = fn;
            OP_JC:  take = fc;
            default: ;
        endcase
        if (acc_we) begin
            flags_we = 1'b1;
            // The extra ext bit is the carry for ADD and the borrow for SUB.
            if (opcode == OP_ADD)
                flags_nx = {res[MSB], res == '0,
                            (acc[MSB] == mem_op[MSB]) && (res[MSB] != acc[MSB]),
                            ext[DATA_W]};
            else if (opcode == OP_SUB)
                flags_nx = {res[MSB], res == '0,
                            (acc[MSB] != mem_op[MSB]) && (res[MSB] != acc[MSB]),
                            ext[DATA_W]};
            else
                flags_nx = {res[MSB], res == '0, 1'b0, 1'b0};
        end
        for (int unsigned k = 0; k < N_OUT; k++)
            out_sel[k] = (opcode == OP_OUT) && (opr_ext == (DATA_W + 5)'(k));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= F1;
            pc     <= '0;
            acc    <= '0;
            ir     <= '0;
            opr    <= '0;
            fn     <= 1'b0;
            fz     <= 1'b0;
            fv     <= 1'b0;
            fc     <= 1'b0;
            saida  <= '0;
            halted <= 1'b0;
        end else if (bus.carga_en) begin
            pc     <= '0;
            state  <= F1;
            halted <= 1'b0;
        end else begin
            case (state)
                F1: begin
                    ir    <= mem_pc[3:0];
                    pc    <= pc + ADDR_W'(1);
                    state <= F2;
                end
                F2: begin
                    opr   <= mem_pc;
                    pc    <= pc + ADDR_W'(1);
                    state <= EX;
                end
                EX: begin
                    if (acc_we)
                        acc <= res;
                    if (flags_we)
                        {fn, fz, fv, fc} <= flags_nx;
                    if (take)
                        pc <= op_addr;
                    for (int unsigned k = 0; k < N_OUT; k++)
                        if (out_sel[k])
                            saida[k*DATA_W +: DATA_W] <= acc;
                    if (opcode == OP_HLT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= F1;
                    end
                end
                HALT: ;
            endcase
        end
    end

    // Memory is never reset; the load port wins over an STA in the same cycle.
    always_ff @(posedge clock) begin
        if (bus.carga_en)
            mem[bus.carga_addr] <= bus.carga_dado;
        else if (state == EX && opcode == OP_STA)
            mem[op_addr] <= acc;
    end

    assign bus.saida  = saida;
    assign bus.halted = halted;
    assign bus.pc     = pc;
endmodule
